// File: rtl/bcd_seg_scan_if.sv
// rtl/bcd_seg_scan_if.sv - digit load and display drive signals of the BCD scanner
interface bcd_seg_scan_if #(
  parameter int DIGITS = 2
);
  logic [4*DIGITS-1:0] bcd_in;
  logic                in_valid;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  modport master (
    output bcd_in,
    output in_valid,
    input  seg,
    input  an,
    input  frame_done
  );

  modport slave (
    input  bcd_in,
    input  in_valid,
    output seg,
    output an,
    output frame_done
  );
endinterface

// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - multiplexed 7-segment BCD scanner (optional BCD_SEG_SCAN_LZB_EN: leading-zero blanking)
module bcd_seg_scan #(
  parameter int DIGITS = 2,
  parameter int DIV    = 4
) (
  input  logic          clk,
  input  logic          rst,
  bcd_seg_scan_if.slave bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PRESC_END = PW'(DIV - 1);

  typedef enum logic {SHOW, GUARD} state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [PW-1:0]       presc;
  logic [4*DIGITS-1:0] disp;
  logic [3:0]          cur_digit;
  logic [6:0]          cur_seg;

  // active-low g..a pattern; 10..15 show a dash
  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'h40;
      4'd1:    encode = 7'h79;
      4'd2:    encode = 7'h24;
      4'd3:    encode = 7'h30;
      4'd4:    encode = 7'h19;
      4'd5:    encode = 7'h12;
      4'd6:    encode = 7'h02;
      4'd7:    encode = 7'h78;
      4'd8:    encode = 7'h00;
      4'd9:    encode = 7'h10;
      default: encode = 7'h3F;
    endcase
  endfunction

  // segment pattern of the digit currently being scanned
`ifdef BCD_SEG_SCAN_LZB_EN
  logic zero_run;
  always_comb begin
    cur_digit = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) cur_digit = disp[4*k +: 4];
    end
    cur_seg  = encode(cur_digit);
    zero_run = 1'b1;
    // walk down from the top digit; blank while every digit at and above is zero
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run = zero_run & (disp[4*k +: 4] == 4'd0);
      if (zero_run && (idx == IW'(k))) cur_seg = 7'h7F;
    end
  end
`else
  always_comb begin
    cur_digit = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) cur_digit = disp[4*k +: 4];
    end
    cur_seg = encode(cur_digit);
  end
`endif

  // digit register: loads whenever in_valid, independent of scan state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp <= '0;
    end else if (bus.in_valid) begin
      disp <= bus.bcd_in;
    end
  end

  // scan FSM; outputs are registered from the pre-edge state so a slot's first cycle is visible right after the edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= SHOW;
      idx            <= '0;
      presc          <= '0;
      bus.seg        <= 7'h7F;
      bus.an         <= '1;
      bus.frame_done <= 1'b0;
    end else begin
      case (state)
        SHOW: begin
          bus.seg        <= cur_seg;
          bus.an         <= ~(DIGITS'(1) << idx);
          bus.frame_done <= 1'b0;
          if (presc == PRESC_END) begin
            state <= GUARD;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        GUARD: begin
          bus.seg        <= 7'h7F;
          bus.an         <= '1;
          bus.frame_done <= (idx == IDX_LAST);
          state          <= SHOW;
          presc          <= '0;
          idx            <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        default: begin
          state <= SHOW;
        end
      endcase
    end
  end

endmodule

// File: doc/bcd_seg_scan.md
BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 Parameter DIGITS, default 2, number of BCD digits / display positions (1..8).
REQ-002 Parameter DIV, default 4, clock cycles each digit is driven per scan slot (>=1).
REQ-003 clk  input  1  rising-edge clock; sole clock of the block.
REQ-004 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 bcd_in  input  4*DIGITS  packed BCD digits; bits [3:0] = digit 0 (ones), [7:4] = digit 1 (tens), and so on.
REQ-006 in_valid  input  1  when high at a rising clk edge, bcd_in is captured.
REQ-007 seg  output  7  active-low segments, seg[0]=a ... seg[6]=g, registered.
REQ-008 an  output  DIGITS  active-low digit enables; an[k]=0 selects digit k; registered.
REQ-009 frame_done  output  1  one-cycle pulse marking the end of a full scan frame; registered.

Function
REQ-010 Digit register disp (4*DIGITS bits) SHALL load bcd_in on any edge with in_valid=1, in any state, with no stall; otherwise it holds.
REQ-011 FSM states: SHOW and GUARD; SHOW lasts exactly DIV cycles, GUARD exactly 1 cycle.
REQ-012 Transitions: SHOW -> GUARD when prescaler = DIV-1; GUARD -> SHOW always, advancing index idx (DIGITS-1 wraps to 0); prescaler clears on entering SHOW.
REQ-013 Frame period SHALL be DIGITS*(DIV+1) cycles; idx sequence is 0,1,...,DIGITS-1,0,...
REQ-014 In SHOW, an SHALL have only bit idx low; in GUARD all an bits SHALL be 1.
REQ-015 seg in SHOW SHALL encode disp digit idx; in GUARD, seg = 7'h7F.
REQ-016 Encoding (g..a, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-017 Digit values 10..15 SHALL display a dash: seg = 7'h3F.
REQ-018 seg/an SHALL reflect disp and state with 1-cycle latency: a value captured at edge N appears on seg at edge N+1 if its digit is in SHOW.
REQ-019 frame_done SHALL be 1 for exactly the cycle in which GUARD of digit DIGITS-1 is output, else 0.
REQ-020 in_valid SHALL NOT alter idx, prescaler or state; only segment content changes.
REQ-021 All arithmetic is unsigned; prescaler and idx widths SHALL be clog2-sized and never exceed their terminal values.

Reset
REQ-022 While rst=0: seg=7'h7F, an=all 1, frame_done=0, disp=0, state=SHOW, idx=0, prescaler=0.
REQ-023 Reset assertion mid-frame SHALL take effect immediately, without waiting for a clock edge; after release, the first edge begins SHOW of digit 0 with a full DIV-cycle slot.
REQ-024 in_valid SHALL be ignored while rst=0.

Configuration
REQ-025 Macro BCD_SEG_SCAN_LZB_EN defined: leading-zero blanking.
- Digit k>0 shows 7'h7F (anode still active) when it and all higher digits equal 0.
- Digit 0 is never blanked.
- A dash digit (10..15) counts as non-zero.
REQ-026 Macro undefined: every digit is shown per REQ-016/017; no blanking logic is present.

Verification (DIGITS=2, DIV=4)
REQ-027 Hold rst=0 for 3 clocks -> seg=7F, an=11, frame_done=0 throughout; asynchronous assertion mid-cycle clears the outputs without waiting for an edge.
REQ-028 Release reset, in_valid pulse with bcd_in=8'h15 -> repeating 10-cycle frame: an=10/seg=12 for 4 cycles, an=11/seg=7F for 1 cycle, an=01/seg=79 for 4 cycles, then guard with frame_done=1 for 1 cycle.
REQ-029 bcd_in=8'h05 -> tens slot seg=7F with the macro defined, seg=40 without it; ones slot seg=12 in both builds.
REQ-030 bcd_in=8'h1B -> ones slot seg=3F, tens slot seg=79; with the macro defined, tens is not blanked.
REQ-031 During ones SHOW cycle 2, load 8'h18 -> seg switches from 12 to 00 on the next edge; an timing and frame_done position are unchanged.
REQ-032 Assert rst during the tens SHOW slot, release -> outputs reset immediately; digit 0 slot restarts with a full 4 cycles; frame_done next fires 10 cycles after release.
